// File: rtl/hit_result_writer_if.sv
// Hit intake and DDR line-write bus of hit_result_writer.
// slave is the writer's own view; master is the pipeline/DDR side driving it.
interface hit_result_writer_if;
    logic         hit_valid;
    logic [31:0]  locationStart;
    logic [31:0]  locationEnd;
    logic         hit_ready;
    logic         flush;
    logic         flush_done;
    logic         ddr_wr;
    logic [31:0]  writeAdd;
    logic [511:0] ddr_wr_data;
    logic         ddr_wr_done;
    logic [15:0]  line_count;
    logic [15:0]  drop_count;
    logic         region_full;

    modport slave (
        input  hit_valid, locationStart, locationEnd, flush, ddr_wr_done,
        output hit_ready, flush_done, ddr_wr, writeAdd, ddr_wr_data,
               line_count, drop_count, region_full
    );

    modport master (
        output hit_valid, locationStart, locationEnd, flush, ddr_wr_done,
        input  hit_ready, flush_done, ddr_wr, writeAdd, ddr_wr_data,
               line_count, drop_count, region_full
    );
endinterface

// File: rtl/hit_result_writer.sv
// Packs 64-bit hit records eight per 512-bit line into ping-pong buffers and writes lines to DDR.
// Optional HIT_DEDUP_EN: discard a hit identical to the last accepted record.
module hit_result_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned MAX_LINES = 4096
) (
    input logic                clk,
    input logic                rst,
    hit_result_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} wrState_t;
    wrState_t state, stateNext;

    logic [511:0] lineBuf [2];
    logic [1:0]   sealed;
    logic         fillSel;
    logic         wrSel;
    logic [2:0]   slotCnt;
    logic         nonEmpty;
    logic         flushPending;
    logic [15:0]  lineCount;
    logic [15:0]  dropCount;
    logic         regionFull;
    logic [31:0]  writeAdd;
    logic [511:0] wrData;

    logic hitReady, isDup, accept, sealFill, flushDone;
    logic loadOut, freeBuf, writeDone, ddrWr;

`ifdef HIT_DEDUP_EN
    logic [31:0] lastStart;
    logic [31:0] lastEnd;
    logic        lastValid;

    assign isDup = lastValid && (lastStart == bus.locationStart) && (lastEnd == bus.locationEnd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastStart <= '0;
            lastEnd   <= '0;
            lastValid <= 1'b0;
        end else if (bus.flush) begin
            lastValid <= 1'b0;
        end else if (accept) begin
            lastStart <= bus.locationStart;
            lastEnd   <= bus.locationEnd;
            lastValid <= 1'b1;
        end
    end
`else
    assign isDup = 1'b0;
`endif

    assign hitReady  = !(&sealed) && !regionFull;
    assign accept    = bus.hit_valid && hitReady && !isDup;
    // A flush coinciding with a hit seals the line that already contains that hit.
    assign sealFill  = !regionFull &&
                       ((accept && slotCnt == 3'd7) || (bus.flush && (nonEmpty || accept)));
    assign flushDone = flushPending && (sealed == 2'b00) && (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        loadOut   = 1'b0;
        freeBuf   = 1'b0;
        writeDone = 1'b0;
        ddrWr     = 1'b0;
        case (state)
            IDLE: begin
                if (sealed[wrSel]) begin
                    // Lines sealed before the region filled cannot be written; drop them.
                    if (regionFull) begin
                        freeBuf = 1'b1;
                    end else begin
                        loadOut   = 1'b1;
                        stateNext = ISSUE;
                    end
                end
            end
            ISSUE: begin
                ddrWr     = 1'b1;
                stateNext = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.ddr_wr_done) begin
                    freeBuf   = 1'b1;
                    writeDone = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lineBuf[0]   <= '0;
            lineBuf[1]   <= '0;
            sealed       <= '0;
            fillSel      <= 1'b0;
            wrSel        <= 1'b0;
            slotCnt      <= '0;
            nonEmpty     <= 1'b0;
            flushPending <= 1'b0;
            lineCount    <= '0;
            dropCount    <= '0;
            regionFull   <= 1'b0;
            writeAdd     <= '0;
            wrData       <= '0;
        end else begin
            if (accept) begin
                lineBuf[fillSel][{slotCnt, 6'd0} +: 64] <= {bus.locationEnd, bus.locationStart};
                slotCnt  <= slotCnt + 3'd1;
                nonEmpty <= 1'b1;
            end
            if (sealFill) begin
                sealed[fillSel] <= 1'b1;
                fillSel         <= ~fillSel;
                slotCnt         <= '0;
                nonEmpty        <= 1'b0;
            end else if (bus.flush && regionFull) begin
                lineBuf[fillSel] <= '0;
                slotCnt          <= '0;
                nonEmpty         <= 1'b0;
            end
            // Freed buffers are zeroed so a later partial line has empty tail slots.
            if (freeBuf) begin
                sealed[wrSel]  <= 1'b0;
                lineBuf[wrSel] <= '0;
                wrSel          <= ~wrSel;
            end
            if (writeDone) begin
                lineCount <= lineCount + 16'd1;
                if (32'(lineCount) + 32'd1 == MAX_LINES) regionFull <= 1'b1;
            end
            if (loadOut) begin
                writeAdd <= BASE_ADDR + {7'd0, lineCount, 9'd0};
                wrData   <= lineBuf[wrSel];
            end
            if (bus.hit_valid && !hitReady && dropCount != 16'hFFFF)
                dropCount <= dropCount + 16'd1;
            if (bus.flush)      flushPending <= 1'b1;
            else if (flushDone) flushPending <= 1'b0;
        end
    end

    assign bus.hit_ready   = hitReady;
    assign bus.flush_done  = flushDone;
    assign bus.ddr_wr      = ddrWr;
    assign bus.writeAdd    = writeAdd;
    assign bus.ddr_wr_data = wrData;
    assign bus.line_count  = lineCount;
    assign bus.drop_count  = dropCount;
    assign bus.region_full = regionFull;
endmodule

// File: tb/tb_hit_result_writer.sv
// Directed bench for hit_result_writer (MAX_LINES=2 so region-full is reachable).
// Define HIT_DEDUP_EN to also exercise duplicate suppression.
module tb_hit_result_writer;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    hit_result_writer_if bus();

    hit_result_writer #(.BASE_ADDR(BASE), .MAX_LINES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned  cyc = 0;
    int unsigned  checkCount = 0;
    int unsigned  errCount = 0;
    int unsigned  wrCount = 0;
    int unsigned  wrCyc = 0;
    int unsigned  doneCyc = 0;
    int unsigned  hitCyc = 0;
    int unsigned  flushDoneCount = 0;
    int unsigned  flushDoneCyc = 0;
    logic [31:0]  addrLog [8];
    logic [511:0] lastData = '0;
    logic [511:0] expLine;
    logic         autoDone = 1'b0;
    logic         doneAuto = 1'b0;
    logic         doneManual = 1'b0;

    assign bus.ddr_wr_done = doneAuto | doneManual;

    always @(posedge clk) cyc <= cyc + 1;

    // DDR responder: logs each write and optionally completes it 3 cycles after ddr_wr.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.ddr_wr) begin
                addrLog[wrCount % 8] = bus.writeAdd;
                lastData = bus.ddr_wr_data;
                wrCyc = cyc;
                wrCount++;
                if (autoDone) begin
                    repeat (2) @(negedge clk);
                    doneAuto = 1'b1;
                    doneCyc = cyc;
                    @(negedge clk);
                    doneAuto = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.flush_done) begin
                flushDoneCount++;
                flushDoneCyc = cyc;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset;
        tick(6);
        rst = 1'b0;
        bus.hit_valid = 1'b0;
        bus.flush = 1'b0;
        doneManual = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic sendHit(input logic [31:0] s, input logic [31:0] e);
        bus.hit_valid = 1'b1;
        bus.locationStart = s;
        bus.locationEnd = e;
        hitCyc = cyc;
        tick(1);
        bus.hit_valid = 1'b0;
    endtask

    task automatic waitWrites(input string tag, input int unsigned target);
        for (int i = 0; i < 100 && wrCount < target; i++) tick(1);
        checkVal(tag, wrCount, target);
    endtask

    task automatic waitFlushDone(input string tag, input int unsigned target);
        for (int i = 0; i < 100 && flushDoneCount < target; i++) tick(1);
        checkVal(tag, flushDoneCount, target);
    endtask

    initial begin
        int unsigned base;
        int unsigned fdBase;
        int unsigned fCyc;
        int          firstBlock;

        bus.hit_valid = 1'b0;
        bus.flush = 1'b0;
        bus.locationStart = '0;
        bus.locationEnd = '0;
        tick(3);
        rst = 1'b1;
        tick(1);
        checkVal("rst_hit_ready", bus.hit_ready, 1);
        checkVal("rst_ddr_wr", bus.ddr_wr, 0);
        checkVal("rst_writeAdd", bus.writeAdd, 0);
        checkVal("rst_wr_data", bus.ddr_wr_data, 0);
        checkVal("rst_flush_done", bus.flush_done, 0);
        checkVal("rst_line_count", bus.line_count, 0);
        checkVal("rst_drop_count", bus.drop_count, 0);
        checkVal("rst_region_full", bus.region_full, 0);

        // Eight hits fill one line.
        autoDone = 1'b1;
        base = wrCount;
        expLine = '0;
        for (int k = 0; k < 8; k++) begin
            expLine[k*64 +: 64] = {32'(k*16 + 10), 32'(k*16)};
            sendHit(32'(k*16), 32'(k*16 + 10));
        end
        waitWrites("t1_writes", base + 1);
        checkVal("t1_latency", wrCyc - hitCyc, 2);
        checkVal("t1_addr", addrLog[base % 8], BASE);
        checkVal("t1_slot3", lastData[255:192], {32'd58, 32'd48});
        checkVal("t1_line", lastData, expLine);
        tick(5);
        checkVal("t1_line_count", bus.line_count, 1);
        checkVal("t1_hit_ready", bus.hit_ready, 1);

        // Three hits then flush: partial line with zero tail.
        doReset();
        base = wrCount;
        fdBase = flushDoneCount;
        expLine = '0;
        for (int k = 0; k < 3; k++) begin
            expLine[k*64 +: 64] = {32'(200 + k), 32'(100 + k)};
            sendHit(32'(100 + k), 32'(200 + k));
        end
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        waitWrites("t2_writes", base + 1);
        checkVal("t2_addr", addrLog[base % 8], BASE);
        checkVal("t2_line", lastData, expLine);
        waitFlushDone("t2_flush_done", fdBase + 1);
        checkVal("t2_flush_timing", flushDoneCyc, doneCyc + 1);
        tick(4);
        checkVal("t2_single_pulse", flushDoneCount, fdBase + 1);

        // Flush with nothing pending: done next cycle, no write.
        base = wrCount;
        fdBase = flushDoneCount;
        fCyc = cyc;
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        tick(3);
        checkVal("t2b_flush_done", flushDoneCount, fdBase + 1);
        checkVal("t2b_flush_timing", flushDoneCyc, fCyc + 1);
        checkVal("t2b_no_write", wrCount, base);

        // Flush in the same cycle as a hit: the hit is in the flushed line.
        base = wrCount;
        expLine = '0;
        expLine[63:0] = {32'd400, 32'd300};
        bus.flush = 1'b1;
        sendHit(32'd300, 32'd400);
        bus.flush = 1'b0;
        waitWrites("t2c_writes", base + 1);
        checkVal("t2c_addr", addrLog[base % 8], BASE + 32'd512);
        checkVal("t2c_line", lastData, expLine);

        // 24 back-to-back hits with completion withheld.
        doReset();
        autoDone = 1'b0;
        base = wrCount;
        firstBlock = -1;
        for (int i = 0; i < 24; i++) begin
            if (!bus.hit_ready && firstBlock < 0) firstBlock = i;
            sendHit(32'(i), 32'(i + 1000));
        end
        tick(3);
        checkVal("t3_first_block", 32'(firstBlock), 16);
        checkVal("t3_drop_count", bus.drop_count, 8);
        checkVal("t3_hit_ready_low", bus.hit_ready, 0);
        checkVal("t3_one_issued", wrCount, base + 1);
        checkVal("t3_lineA_slot7", lastData[511:448], {32'd1007, 32'd7});
        doneManual = 1'b1;
        tick(1);
        doneManual = 1'b0;
        checkVal("t3_hit_ready_back", bus.hit_ready, 1);
        checkVal("t3_line_count1", bus.line_count, 1);
        waitWrites("t3_writes", base + 2);
        checkVal("t3_addrB", addrLog[(base + 1) % 8], BASE + 32'd512);
        checkVal("t3_lineB_slot0", lastData[63:0], {32'd1008, 32'd8});
        tick(1);
        doneManual = 1'b1;
        tick(1);
        doneManual = 1'b0;
        checkVal("t3_line_count2", bus.line_count, 2);

        // Region fills after two lines; later hits are dropped.
        doReset();
        autoDone = 1'b1;
        base = wrCount;
        for (int i = 0; i < 16; i++) sendHit(32'(i*2), 32'(i*2 + 1));
        waitWrites("t4_writes", base + 2);
        tick(6);
        checkVal("t4_addr0", addrLog[base % 8], BASE);
        checkVal("t4_addr1", addrLog[(base + 1) % 8], BASE + 32'd512);
        checkVal("t4_region_full", bus.region_full, 1);
        checkVal("t4_line_count", bus.line_count, 2);
        for (int i = 0; i < 4; i++) sendHit(32'(i + 50), 32'(i + 60));
        checkVal("t4_drop_count", bus.drop_count, 4);
        checkVal("t4_hit_ready", bus.hit_ready, 0);
        fdBase = flushDoneCount;
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        tick(3);
        checkVal("t4_flush_done", flushDoneCount, fdBase + 1);
        checkVal("t4_no_write", wrCount, base + 2);

        // Reset while a write is outstanding.
        doReset();
        autoDone = 1'b0;
        base = wrCount;
        for (int i = 0; i < 8; i++) sendHit(32'(i + 7), 32'(i + 9));
        waitWrites("t5_issued", base + 1);
        tick(2);
        rst = 1'b0;
        #1;
        checkVal("t5_async_writeAdd", bus.writeAdd, 0);
        checkVal("t5_async_data", bus.ddr_wr_data, 0);
        tick(2);
        rst = 1'b1;
        tick(1);
        doneManual = 1'b1;
        tick(1);
        doneManual = 1'b0;
        tick(3);
        checkVal("t5_line_count", bus.line_count, 0);
        checkVal("t5_ddr_wr", bus.ddr_wr, 0);
        checkVal("t5_hit_ready", bus.hit_ready, 1);
        checkVal("t5_no_new_write", wrCount, base + 1);
        checkVal("t5_drop_count", bus.drop_count, 0);

`ifdef HIT_DEDUP_EN
        // Repeated hit collapses to one slot.
        doReset();
        autoDone = 1'b1;
        base = wrCount;
        for (int i = 0; i < 3; i++) sendHit(32'd5, 32'd6);
        sendHit(32'd7, 32'd8);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        waitWrites("dd_writes", base + 1);
        checkVal("dd_slots", lastData[127:0], {32'd8, 32'd7, 32'd6, 32'd5});
        checkVal("dd_tail", lastData[511:128], 0);
        checkVal("dd_drop_count", bus.drop_count, 0);
`endif

        tick(6);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end
endmodule
